// File: rtl/pong_pkg.sv
// Shared state encodings, playfield constants and widths for the Pong match logic.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } match_state_t;

  localparam int unsigned FIELD_W = 20;
  localparam int unsigned FIELD_H = 15;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned BALL_XW = 5;

endpackage

// File: rtl/tick_divider.sv
// Free-running game-tick divider. A new period is adopted only at the wrap,
// so the interval already in progress is never cut short.
module tick_divider #(
  parameter int unsigned MAX_PERIOD = 4,
  parameter int unsigned PW         = $clog2(MAX_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] period,
  output logic          tick
);

  logic [PW-1:0] cnt;
  logic [PW-1:0] period_q;

  assign tick = (cnt == period_q - PW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      period_q <= PW'(MAX_PERIOD);
    end else if (tick) begin
      cnt      <= '0;
      period_q <= period;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/pong_match_sequencer.sv
// Match sequencer: gates game ticks into STEP_EN, scores goals, serve delay, winner.
// Optional PONG_SPEEDUP_EN: each goal raises a speed level (max 2), period = TICK_DIV >> level.
module pong_match_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 6250000,
  parameter int unsigned W           = FIELD_W,
  parameter int unsigned SERVE_TICKS = 8,
  parameter int unsigned WIN_SCORE   = 7
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [BALL_XW-1:0] BALL_X,
  output logic               STEP_EN,
  output logic [SCORE_W-1:0] PLAYER_SCORE,
  output logic [SCORE_W-1:0] COM_SCORE,
  output logic [1:0]         STATE,
  output logic               GAME_OVER,
  output logic               WINNER
);

  localparam int unsigned PW  = $clog2(TICK_DIV + 1);
  localparam int unsigned SCW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  match_state_t       state;
  match_state_t       state_nxt;
  logic               start_q;
  logic               start_prev;
  logic               start_edge;
  logic               tick;
  logic [PW-1:0]      period;
  logic [SCW-1:0]     serve_cnt;
  logic [SCW-1:0]     serve_cnt_nxt;
  logic [SCORE_W-1:0] player_inc;
  logic [SCORE_W-1:0] com_inc;
  logic [SCORE_W-1:0] player_nxt;
  logic [SCORE_W-1:0] com_nxt;
  logic               goal_com;
  logic               goal_player;
  logic               goal_tick;
  logic               serve_done;
  logic               win;
  logic               step_nxt;
  logic               winner_nxt;

  assign start_edge  = start_q & ~start_prev;
  assign goal_com    = (BALL_X == BALL_XW'(0));
  assign goal_player = (BALL_X == BALL_XW'(W - 1));
  assign goal_tick   = tick & (goal_com | goal_player);
  assign serve_done  = tick & (serve_cnt == SCW'(SERVE_TICKS - 1));
  assign player_inc  = (PLAYER_SCORE == '1) ? PLAYER_SCORE : PLAYER_SCORE + SCORE_W'(1);
  assign com_inc     = (COM_SCORE == '1) ? COM_SCORE : COM_SCORE + SCORE_W'(1);
  assign win         = (goal_com    && (com_inc    == SCORE_W'(WIN_SCORE))) ||
                       (goal_player && (player_inc == SCORE_W'(WIN_SCORE)));
  assign STATE       = state;

`ifdef PONG_SPEEDUP_EN
  logic [1:0] level;
  logic [1:0] level_nxt;
  assign period = PW'(TICK_DIV >> level);
`else
  assign period = PW'(TICK_DIV);
`endif

  tick_divider #(
    .MAX_PERIOD (TICK_DIV),
    .PW         (PW)
  ) u_tick_divider (
    .clk    (CLK),
    .rst    (RST),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = SERVE;
      SERVE:   if (serve_done) state_nxt = PLAY;
      PLAY:    if (goal_tick)  state_nxt = win ? OVER : SERVE;
      OVER:    if (start_edge) state_nxt = SERVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    step_nxt      = (state == PLAY) && tick;
    player_nxt    = PLAYER_SCORE;
    com_nxt       = COM_SCORE;
    winner_nxt    = WINNER;
    serve_cnt_nxt = serve_cnt;
`ifdef PONG_SPEEDUP_EN
    level_nxt     = level;
`endif
    case (state)
      IDLE, OVER: begin
        if (start_edge) begin
          player_nxt    = '0;
          com_nxt       = '0;
          winner_nxt    = 1'b0;
          serve_cnt_nxt = '0;
`ifdef PONG_SPEEDUP_EN
          level_nxt     = 2'd0;
`endif
        end
      end
      SERVE: if (tick) serve_cnt_nxt = serve_cnt + SCW'(1);
      PLAY: begin
        // The goal step doubles as the recenter step, so it is issued even on the winning goal.
        if (goal_tick) begin
          if (goal_com) com_nxt    = com_inc;
          else          player_nxt = player_inc;
          if (win)      winner_nxt = goal_com;
          serve_cnt_nxt = '0;
`ifdef PONG_SPEEDUP_EN
          level_nxt     = (level == 2'd2) ? level : level + 2'd1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      start_q      <= 1'b0;
      start_prev   <= 1'b0;
      STEP_EN      <= 1'b0;
      PLAYER_SCORE <= '0;
      COM_SCORE    <= '0;
      GAME_OVER    <= 1'b0;
      WINNER       <= 1'b0;
      serve_cnt    <= '0;
`ifdef PONG_SPEEDUP_EN
      level        <= 2'd0;
`endif
    end else begin
      start_q      <= START;
      start_prev   <= start_q;
      STEP_EN      <= step_nxt;
      PLAYER_SCORE <= player_nxt;
      COM_SCORE    <= com_nxt;
      GAME_OVER    <= (state_nxt == OVER);
      WINNER       <= winner_nxt;
      serve_cnt    <= serve_cnt_nxt;
`ifdef PONG_SPEEDUP_EN
      level        <= level_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Bench for pong_match_sequencer: directed match walk-through plus random play
// against a tick-level behavioural model of the match rules.
module tb_pong_match_sequencer;

  localparam int TICK_DIV    = 4;
  localparam int W           = 20;
  localparam int SERVE_TICKS = 2;
  localparam int WIN_SCORE   = 2;
`ifdef PONG_SPEEDUP_EN
  localparam int QUIET = 7;
`else
  localparam int QUIET = 11;
`endif

  logic       CLK    = 1'b0;
  logic       RST    = 1'b1;
  logic       START  = 1'b0;
  logic [4:0] BALL_X = 5'd10;
  logic       STEP_EN;
  logic [3:0] PLAYER_SCORE;
  logic [3:0] COM_SCORE;
  logic [1:0] STATE;
  logic       GAME_OVER;
  logic       WINNER;

  int n_cmp = 0;
  int n_bad = 0;

  // model of the match: 0 IDLE, 1 SERVE, 2 PLAY, 3 OVER
  int m_phase, m_per, m_level, m_state, m_ps, m_cs, m_serve_left;
  bit m_sq, m_sp, m_step, m_over, m_win;

  always #5 CLK = ~CLK;

  pong_match_sequencer #(
    .TICK_DIV    (TICK_DIV),
    .W           (W),
    .SERVE_TICKS (SERVE_TICKS),
    .WIN_SCORE   (WIN_SCORE)
  ) u_dut (
    .CLK          (CLK),
    .RST          (RST),
    .START        (START),
    .BALL_X       (BALL_X),
    .STEP_EN      (STEP_EN),
    .PLAYER_SCORE (PLAYER_SCORE),
    .COM_SCORE    (COM_SCORE),
    .STATE        (STATE),
    .GAME_OVER    (GAME_OVER),
    .WINNER       (WINNER)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_per = TICK_DIV; m_level = 0; m_state = 0;
    m_ps = 0; m_cs = 0; m_serve_left = 0;
    m_sq = 0; m_sp = 0; m_step = 0; m_over = 0; m_win = 0;
  endtask

  task automatic model_step();
    bit tk, edg, gc, gp;
    if (RST) begin
      model_reset();
      return;
    end
    tk  = (m_phase == m_per - 1);
    edg = m_sq && !m_sp;
    m_sp = m_sq;
    m_sq = START;
    if (tk) begin
      m_phase = 0;
`ifdef PONG_SPEEDUP_EN
      m_per = TICK_DIV >> m_level;
`endif
    end else begin
      m_phase++;
    end
    m_step = (m_state == 2) && tk;
    gc = (BALL_X == 0);
    gp = (BALL_X == W - 1);
    case (m_state)
      0, 3: if (edg) begin
        m_state = 1; m_ps = 0; m_cs = 0; m_win = 0;
        m_serve_left = SERVE_TICKS; m_level = 0;
      end
      1: if (tk) begin
        m_serve_left--;
        if (m_serve_left == 0) m_state = 2;
      end
      2: if (tk && (gc || gp)) begin
        if (gc) m_cs = (m_cs < 15) ? m_cs + 1 : 15;
        else    m_ps = (m_ps < 15) ? m_ps + 1 : 15;
        if (m_level < 2) m_level++;
        if ((gc ? m_cs : m_ps) == WIN_SCORE) begin
          m_state = 3;
          m_win = gc;
        end else begin
          m_state = 1;
          m_serve_left = SERVE_TICKS;
        end
      end
      default: ;
    endcase
    m_over = (m_state == 3);
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    chk("step_en",   STEP_EN,      m_step);
    chk("player",    PLAYER_SCORE, m_ps);
    chk("com",       COM_SCORE,    m_cs);
    chk("state",     STATE,        m_state);
    chk("game_over", GAME_OVER,    m_over);
    chk("winner",    WINNER,       m_win);
  endtask

  task automatic wait_step(input int budget, input string tag, output int waited);
    waited = 0;
    do begin
      cycle();
      waited++;
    end while (!STEP_EN && waited < budget);
    chk({tag, "_seen"}, STEP_EN, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int steps;
    model_reset();

    RST = 1'b1;
    cycle();
    cycle();
    RST = 1'b0;
    chk("rst_state",  STATE,        0);
    chk("rst_step",   STEP_EN,      0);
    chk("rst_player", PLAYER_SCORE, 0);
    chk("rst_com",    COM_SCORE,    0);
    chk("rst_over",   GAME_OVER,    0);
    chk("rst_winner", WINNER,       0);

    steps = 0;
    repeat (40) begin
      cycle();
      steps += int'(STEP_EN);
    end
    chk("idle_steps", steps, 0);
    chk("idle_state", STATE, 0);

    START = 1'b1;
    cycle();
    chk("start_lat1", STATE, 0);
    cycle();
    chk("start_lat2", STATE, 1);
    START = 1'b0;

    wait_step(20, "first_step", w);
    chk("first_step_window", (w >= 9 && w <= 12), 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("step_width", STEP_EN, 0);
      wait_step(12, "spacing", w);
      chk("step_spacing", w + 1, TICK_DIV);
    end

    BALL_X = 5'd0;
    wait_step(12, "goal_com", w);
    chk("goal_com_score", COM_SCORE, 1);
    chk("goal_com_state", STATE, 1);
    BALL_X = 5'd10;
    steps = 0;
    repeat (QUIET) begin
      cycle();
      steps += int'(STEP_EN);
    end
    chk("serve_quiet", steps, 0);
    wait_step(4, "serve_resume", w);
    chk("serve_resume_lat", w, 1);

    BALL_X = 5'd19;
    wait_step(12, "goal_p1", w);
    chk("goal_p1_score", PLAYER_SCORE, 1);
    chk("goal_p1_state", STATE, 1);
    wait_step(20, "goal_p2", w);
    chk("win_player", PLAYER_SCORE, 2);
    chk("win_state",  STATE, 3);
    chk("win_over",   GAME_OVER, 1);
    chk("win_winner", WINNER, 0);
    BALL_X = 5'd10;
    repeat (5) cycle();
    chk("over_frozen", PLAYER_SCORE, 2);

    START = 1'b1;
    cycle();
    cycle();
    chk("restart_state",  STATE, 1);
    chk("restart_player", PLAYER_SCORE, 0);
    chk("restart_com",    COM_SCORE, 0);
    chk("restart_over",   GAME_OVER, 0);
    repeat (30) cycle();
    chk("hold_state", STATE, 2);
    START = 1'b0;

    BALL_X = 5'd0;
    wait_step(12, "pre_rst_goal", w);
    chk("pre_rst_com", COM_SCORE, 1);
    BALL_X = 5'd10;
    wait_step(20, "pre_rst_play", w);
    chk("pre_rst_state", STATE, 2);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    chk("mid_rst_state", STATE, 0);
    chk("mid_rst_com",   COM_SCORE, 0);
    chk("mid_rst_step",  STEP_EN, 0);
    chk("mid_rst_over",  GAME_OVER, 0);

    for (int i = 0; i < 4000; i++) begin
      RST = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) START = ~START;
      case ($urandom_range(0, 3))
        0:       BALL_X = 5'd0;
        1:       BALL_X = 5'd19;
        default: BALL_X = 5'($urandom_range(0, 31));
      endcase
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_match_sequencer.md
# pong_match_sequencer

Match-level controller for the Pong game logic. Divides the system clock into game ticks and gates them into a single-cycle step strobe that advances the paddle/ball update logic. Detects goals from the ball column, keeps both scores, holds a serve delay after each goal, and declares a winner. Sits between the VGA-domain system clock and the game-state controller; the score and state outputs feed the display overlay.

## Interface
- `TICK_DIV`, default 6250000: system clocks per game tick, minimum 4.
- `W`, default 20: playfield width in cells; goal columns are 0 and W-1.
- `SERVE_TICKS`, default 8: ticks of stepless pause before each serve, minimum 1.
- `WIN_SCORE`, default 7: score that ends the match, range 1..15.

- `CLK`  in  1  system clock; the single clock of the block.
- `RST`  in  1  synchronous, active-high reset.
- `START`  in  1  start/restart button, active-high level, already debounced.
- `BALL_X`  in  5  current ball column from the game-state controller.
- `STEP_EN`  out  1  one-cycle strobe; the game-state controller advances exactly once per pulse.
- `PLAYER_SCORE`  out  4  left-side score.
- `COM_SCORE`  out  4  right-side score.
- `STATE`  out  2  0 IDLE, 1 SERVE, 2 PLAY, 3 OVER.
- `GAME_OVER`  out  1  high while in OVER.
- `WINNER`  out  1  0 player, 1 com; valid while GAME_OVER is high.

## Operation
- Tick divider: free-running counter 0..period-1 from reset; `tick` is internal and high when counter == period-1.
- START rising edge: registered START compared with its previous value; only the edge acts.
- IDLE: on START edge, clear both scores and go to SERVE with the serve count cleared.
- SERVE: count ticks; on the SERVE_TICKS-th tick go to PLAY. STEP_EN is never asserted in SERVE.
- PLAY: on each tick, assert STEP_EN. At the same tick, sample BALL_X:
  - BALL_X == 0: COM_SCORE +1.
  - BALL_X == W-1: PLAYER_SCORE +1.
  - After a goal, if the new score == WIN_SCORE, go to OVER and set WINNER. Otherwise go to SERVE.
  - The STEP_EN issued on a goal tick is the recenter step; it is issued even when going to OVER.
- OVER: scores and WINNER frozen. START edge clears scores and WINNER and goes to SERVE.
- A START edge in SERVE or PLAY is ignored.
- Scores saturate at 15; they cannot wrap, because WIN_SCORE ≤ 15 ends the match first.

## Timing
- Reset values: STEP_EN 0, PLAYER_SCORE 0, COM_SCORE 0, STATE 0 (IDLE), GAME_OVER 0, WINNER 0, divider 0, speed level 0.
- All outputs are registered.
- STEP_EN is high for exactly one CLK, the cycle after the tick cycle. Consecutive pulses are exactly one period apart within PLAY.
- Score, STATE, GAME_OVER and WINNER update in the same cycle as the STEP_EN pulse that carries the goal.
- START-edge latency to STATE change: 2 CLK (1 sync register plus 1 FSM register).
- First STEP_EN after entering SERVE arrives SERVE_TICKS+1 ticks later.
- RST asserted mid-match: next edge returns every register to its reset value. Any in-progress step is dropped.

## Configuration
- `PONG_SPEEDUP_EN` defined:
  - A 2-bit speed level increments on each goal, saturating at 2.
  - Divider period = TICK_DIV >> level.
  - The new period takes effect at the next divider wrap.
  - Level clears on the START edge that begins a match.
- Not defined: period is fixed at TICK_DIV and no level register exists.

## Structure
- Shared package `pong_pkg`:
  - state encodings IDLE/SERVE/PLAY/OVER
  - playfield constants W=20, H=15
  - score width 4
- One sub-module: `tick_divider` (counter plus period input, outputs `tick`). The FSM, scoring and edge detector stay in the top level.

## Test plan
Parameters for all tests: TICK_DIV=4, SERVE_TICKS=2, WIN_SCORE=2, W=20.
- Reset then idle for 40 CLK -> STEP_EN never high, STATE=0, scores 0.
- START pulse at idle -> STATE=1 after 2 CLK. First STEP_EN comes 3 ticks later, then pulses every 4 CLK, each 1 CLK wide.
- In PLAY, BALL_X=0 at a tick -> STEP_EN pulse, COM_SCORE=1 and STATE=1 in the same cycle. No STEP_EN for the next 2 ticks.
- Two BALL_X=19 goals -> PLAYER_SCORE=2, STATE=3, GAME_OVER=1, WINNER=0. START held high in OVER does nothing more after its first edge, which returns STATE=1 with scores 0.
- RST asserted for 1 CLK during PLAY with COM_SCORE=1 -> all outputs at reset values the next cycle.
- With `PONG_SPEEDUP_EN`, after the first goal -> STEP_EN spacing becomes 2 CLK. After the third goal it stays at 1 CLK (4>>2).
